// File: rtl/qspi_arb_pkg.sv
// qspi_arb shared definitions: requester indices, FSM states,
// rom_mode encodings and the device-select helper.
package qspi_arb_pkg;

    localparam logic [1:0] REQ_I = 2'd0;
    localparam logic [1:0] REQ_D = 2'd1;
    localparam logic [1:0] REQ_X = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [1:0] RM_SPLIT2 = 2'b00;
    localparam logic [1:0] RM_ZERO   = 2'b01;
    localparam logic [1:0] RM_SPLIT1 = 2'b10;
    localparam logic [1:0] RM_DIR    = 2'b11;

    function automatic logic [1:0] mem_sel(
        input logic [1:0] mode,
        input logic       msb,
        input logic       is_i,
        input logic       wr
    );
        logic [1:0] m;
        m = 2'd0;
        case (mode)
            RM_SPLIT2: m = msb ? 2'd2 : 2'd0;
            RM_ZERO:   m = 2'd0;
            RM_SPLIT1: m = msb ? 2'd1 : 2'd0;
            default:   m = (is_i || !wr) ? 2'd1 : 2'd0;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = REQ_I;
        if (oh[2])
            idx = REQ_X;
        else if (oh[1])
            idx = REQ_D;
        return idx;
    endfunction

endpackage

// File: rtl/qspi_arb_if.sv
// Requester and qspi-engine bundle of the arbiter.
// slave = arbiter side, master = requesters/engine side.
interface qspi_arb_if #(
    parameter int PA          = 24,
    parameter int LINE_LENGTH = 4
);
    localparam int TAG_W = PA - $clog2(LINE_LENGTH);

    logic             i_req;
    logic [TAG_W-1:0] i_tag;
    logic             i_done;
    logic             d_req;
    logic             d_write;
    logic [TAG_W-1:0] d_tag;
    logic             d_done;
    logic             x_req;
    logic             x_write;
    logic [TAG_W-1:0] x_tag;
    logic             x_done;
    logic [2:0]       gnt;
    logic             m_req;
    logic             m_i_d;
    logic             m_write;
    logic [TAG_W-1:0] m_paddr;
    logic [1:0]       m_mem;
    logic             m_done;
    logic             busy;
    logic             timeout;

    modport slave (
        input  i_req, i_tag, d_req, d_write, d_tag,
        input  x_req, x_write, x_tag, m_done,
        output i_done, d_done, x_done, gnt, m_req, m_i_d,
        output m_write, m_paddr, m_mem, busy, timeout
    );

    modport master (
        output i_req, i_tag, d_req, d_write, d_tag,
        output x_req, x_write, x_tag, m_done,
        input  i_done, d_done, x_done, gnt, m_req, m_i_d,
        input  m_write, m_paddr, m_mem, busy, timeout
    );

endinterface

// File: rtl/qspi_arb_rr_pick3.sv
// Combinational 3-way round-robin picker; searches from the
// requester after last, wrapping 0 -> 1 -> 2 -> 0.
module rr_pick3
    import qspi_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    // priority rotation keyed on the previous winner
    always_comb begin
        gnt = 3'b000;
        case (last)
            REQ_I: begin
                if (req[REQ_D])      gnt = 3'b010;
                else if (req[REQ_X]) gnt = 3'b100;
                else if (req[REQ_I]) gnt = 3'b001;
            end
            REQ_D: begin
                if (req[REQ_X])      gnt = 3'b100;
                else if (req[REQ_I]) gnt = 3'b001;
                else if (req[REQ_D]) gnt = 3'b010;
            end
            default: begin
                if (req[REQ_I])      gnt = 3'b001;
                else if (req[REQ_D]) gnt = 3'b010;
                else if (req[REQ_X]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/qspi_arb.sv
// Locked, fair arbiter for the shared QSPI line-transfer engine.
// Grant is held until m_done or the watchdog expires.
module qspi_arb #(
    parameter int PA          = 24,
    parameter int LINE_LENGTH = 4,
    parameter int TIMEOUT     = 1023,
    parameter int TW          = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rom_mode,
    qspi_arb_if.slave  bus
);
    import qspi_arb_pkg::*;

    localparam int TAG_W = PA - $clog2(LINE_LENGTH);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic             m_req_q, m_req_d;
    logic             m_i_d_q, m_i_d_d;
    logic             m_write_q, m_write_d;
    logic [TAG_W-1:0] m_paddr_q, m_paddr_d;
    logic [1:0]       m_mem_q, m_mem_d;
    logic [2:0]       done_q, done_d;
    logic             tmo_q, tmo_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [2:0]       req;
    logic [2:0]       pick;
    logic [TAG_W-1:0] sel_tag;
    logic             sel_wr;
    logic             sel_i;

    assign req = {bus.x_req, bus.d_req, bus.i_req};

    rr_pick3 u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (pick)
    );

    // fields of the requester chosen by the picker
    always_comb begin
        sel_tag = '0;
        sel_wr  = 1'b0;
        sel_i   = 1'b0;
        unique case (1'b1)
            pick[REQ_I]: begin
                sel_tag = bus.i_tag;
                sel_i   = 1'b1;
            end
            pick[REQ_D]: begin
                sel_tag = bus.d_tag;
                sel_wr  = bus.d_write;
            end
            pick[REQ_X]: begin
                sel_tag = bus.x_tag;
                sel_wr  = bus.x_write;
            end
            default: ;
        endcase
    end

    // next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        m_req_d   = m_req_q;
        m_i_d_d   = m_i_d_q;
        m_write_d = m_write_q;
        m_paddr_d = m_paddr_q;
        m_mem_d   = m_mem_q;
        done_d    = 3'b000;
        tmo_d     = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d     = pick;
                    m_req_d   = 1'b1;
                    m_i_d_d   = sel_i;
                    m_write_d = sel_wr;
                    m_paddr_d = sel_tag;
                    m_mem_d   = mem_sel(rom_mode, sel_tag[TAG_W-1],
                                        sel_i, sel_wr);
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (bus.m_done) begin
                    m_req_d = 1'b0;
                    done_d  = gnt_q;
                    last_d  = oh2idx(gnt_q);
                    gnt_d   = 3'b000;
                    state_d = RECOVER;
                end else if (cnt_q == CNT_LAST) begin
                    m_req_d = 1'b0;
                    tmo_d   = 1'b1;
                    last_d  = oh2idx(gnt_q);
                    gnt_d   = 3'b000;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            m_req_q   <= 1'b0;
            m_i_d_q   <= 1'b0;
            m_write_q <= 1'b0;
            m_paddr_q <= '0;
            m_mem_q   <= 2'd0;
            done_q    <= 3'b000;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
            last_q    <= REQ_X;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            m_req_q   <= m_req_d;
            m_i_d_q   <= m_i_d_d;
            m_write_q <= m_write_d;
            m_paddr_q <= m_paddr_d;
            m_mem_q   <= m_mem_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.m_req   = m_req_q;
    assign bus.m_i_d   = m_i_d_q;
    assign bus.m_write = m_write_q;
    assign bus.m_paddr = m_paddr_q;
    assign bus.m_mem   = m_mem_q;
    assign bus.i_done  = done_q[REQ_I];
    assign bus.d_done  = done_q[REQ_D];
    assign bus.x_done  = done_q[REQ_X];
    assign bus.timeout = tmo_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_arb.sv
// Scoreboard bench for qspi_arb: expected grants are queued when
// requests are driven and compared when m_req rises.
module tb_qspi_arb;

    localparam int PA    = 24;
    localparam int LL    = 4;
    localparam int TAG_W = 22;

    typedef struct {
        logic [2:0]       gnt;
        logic             i_d;
        logic             wr;
        logic [TAG_W-1:0] tag;
        logic [1:0]       mem;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rom_mode = 2'b00;

    qspi_arb_if #(.PA(PA), .LINE_LENGTH(LL)) bus ();

    qspi_arb #(
        .PA(PA), .LINE_LENGTH(LL), .TIMEOUT(8), .TW(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rom_mode (rom_mode),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] dones();
        return {bus.x_done, bus.d_done, bus.i_done};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop_all();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.x_req = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] who,
                             input logic [TAG_W-1:0] tag,
                             input logic wr);
        if (who[0]) begin
            bus.i_req = 1'b1;
            bus.i_tag = tag;
        end
        if (who[1]) begin
            bus.d_req   = 1'b1;
            bus.d_tag   = tag;
            bus.d_write = wr;
        end
        if (who[2]) begin
            bus.x_req   = 1'b1;
            bus.x_tag   = tag;
            bus.x_write = wr;
        end
    endtask

    task automatic expect_grant(input logic [2:0] who,
                                input logic [TAG_W-1:0] tag,
                                input logic wr,
                                input logic [1:0] mem);
        exp_t e;
        e.gnt = who;
        e.i_d = who[0];
        e.wr  = who[0] ? 1'b0 : wr;
        e.tag = tag;
        e.mem = mem;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input string tag, output int n);
        exp_t e;
        n = 0;
        while (bus.m_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_mreq"}, 32'(bus.m_req), 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
            check({tag, "_i_d"}, 32'(bus.m_i_d), 32'(e.i_d));
            check({tag, "_wr"}, 32'(bus.m_write), 32'(e.wr));
            check({tag, "_paddr"}, 32'(bus.m_paddr), 32'(e.tag));
            check({tag, "_mem"}, 32'(bus.m_mem), 32'(e.mem));
        end
    endtask

    task automatic finish_xfer(input string tag, input logic [2:0] who,
                               input int dly, input bit hold);
        tick(dly);
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        check({tag, "_done"}, 32'(dones()), 32'(who));
        check({tag, "_mreq_off"}, 32'(bus.m_req), 0);
        check({tag, "_recover"}, 32'(bus.busy), 1);
        if (!hold)
            drop_all();
        tick();
        check({tag, "_done_1cy"}, 32'(dones()), 0);
        check({tag, "_idle"}, 32'(bus.busy), 0);
        check({tag, "_idle_mreq"}, 32'(bus.m_req), 0);
    endtask

    task automatic do_reset();
        drop_all();
        bus.m_done = 1'b0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    logic [2:0]       t_who[5]  = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b100};
    logic [TAG_W-1:0] t_tag[5]  = '{22'h00F0F0, 22'h00F0F0, 22'h200001,
                                    22'h3ABCDE, 22'h3ABCDE};
    logic             t_wr[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]       t_mode[5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0]       t_mem[5]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0] who;
        bus.i_req = 1'b0;
        bus.i_tag = '0;
        bus.d_req = 1'b0;
        bus.d_write = 1'b0;
        bus.d_tag = '0;
        bus.x_req = 1'b0;
        bus.x_write = 1'b0;
        bus.x_tag = '0;
        bus.m_done = 1'b0;

        // reset values
        tick(2);
        check("rst_mreq", 32'(bus.m_req), 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_tmo", 32'(bus.timeout), 0);
        check("rst_done", 32'(dones()), 0);
        check("rst_paddr", 32'(bus.m_paddr), 0);
        check("rst_mem", 32'(bus.m_mem), 0);
        check("rst_wr_id", 32'({bus.m_write, bus.m_i_d}), 0);
        reset = 1'b1;

        // single I fill, m_done at cycle 5
        rom_mode = 2'b00;
        drive_req(3'b001, 22'h012345, 1'b0);
        expect_grant(3'b001, 22'h012345, 1'b0, 2'd0);
        wait_grant("t1", n);
        check("t1_latency", 32'(n), 1);
        finish_xfer("t1", 3'b001, 4, 1'b0);

        // fairness with all three requesting
        do_reset();
        drive_req(3'b001, 22'h00ABCD, 1'b0);
        drive_req(3'b010, 22'h2AAAAA, 1'b1);
        drive_req(3'b100, 22'h011111, 1'b0);
        expect_grant(3'b001, 22'h00ABCD, 1'b0, 2'd0);
        expect_grant(3'b010, 22'h2AAAAA, 1'b1, 2'd2);
        expect_grant(3'b100, 22'h011111, 1'b0, 2'd0);
        expect_grant(3'b001, 22'h00ABCD, 1'b0, 2'd0);
        expect_grant(3'b010, 22'h2AAAAA, 1'b1, 2'd2);
        for (int k = 0; k < 5; k++) begin
            who = sb[0].gnt;
            wait_grant("fair", n);
            check("fair_gap", 32'(n), 1);
            finish_xfer("fair", who, 3, k < 4);
        end

        // device select table
        for (int k = 0; k < 5; k++) begin
            rom_mode = t_mode[k];
            drive_req(t_who[k], t_tag[k], t_wr[k]);
            expect_grant(t_who[k], t_tag[k], t_wr[k], t_mem[k]);
            wait_grant("mem", n);
            finish_xfer("mem", t_who[k], 3, 1'b0);
        end

        // watchdog abort on X, then I wins over D
        rom_mode = 2'b00;
        drive_req(3'b100, 22'h012345, 1'b1);
        expect_grant(3'b100, 22'h012345, 1'b1, 2'd0);
        wait_grant("to", n);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("to_hold", 32'({bus.m_req, bus.timeout}), 32'h2);
        end
        tick();
        check("to_mreq", 32'(bus.m_req), 0);
        check("to_pulse", 32'(bus.timeout), 1);
        check("to_nodone", 32'(dones()), 0);
        drop_all();
        drive_req(3'b001, 22'h001234, 1'b0);
        drive_req(3'b010, 22'h005678, 1'b1);
        expect_grant(3'b001, 22'h001234, 1'b0, 2'd0);
        tick();
        check("to_pulse_1cy", 32'(bus.timeout), 0);
        check("to_nodone2", 32'(dones()), 0);
        wait_grant("to_next", n);
        finish_xfer("to_next", 3'b001, 3, 1'b0);

        // inputs and rom_mode change during BUSY
        rom_mode = 2'b10;
        drive_req(3'b010, 22'h2C0DE5, 1'b1);
        expect_grant(3'b010, 22'h2C0DE5, 1'b1, 2'd1);
        wait_grant("hold", n);
        tick();
        bus.d_tag = 22'h000111;
        bus.d_write = 1'b0;
        bus.d_req = 1'b0;
        rom_mode = 2'b00;
        tick();
        check("hold_paddr", 32'(bus.m_paddr), 32'h2C0DE5);
        check("hold_wr", 32'(bus.m_write), 1);
        check("hold_mem", 32'(bus.m_mem), 1);
        check("hold_mreq", 32'(bus.m_req), 1);
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        check("hold_done", 32'(dones()), 32'h2);
        tick();
        check("hold_done_1cy", 32'(dones()), 0);

        // stray m_done while IDLE
        tick();
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        check("stray_done", 32'(dones()), 0);
        check("stray_busy", 32'(bus.busy), 0);
        tick();
        check("stray_done2", 32'(dones()), 0);
        check("stray_mreq", 32'(bus.m_req), 0);

        // asynchronous reset mid-transfer
        drive_req(3'b100, 22'h012321, 1'b0);
        expect_grant(3'b100, 22'h012321, 1'b0, 2'd0);
        wait_grant("arst", n);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_mreq", 32'(bus.m_req), 0);
        check("arst_gnt", 32'(bus.gnt), 0);
        check("arst_busy", 32'(bus.busy), 0);
        drop_all();
        tick(2);
        reset = 1'b1;
        drive_req(3'b010, 22'h000222, 1'b0);
        drive_req(3'b001, 22'h000333, 1'b0);
        expect_grant(3'b001, 22'h000333, 1'b0, 2'd0);
        wait_grant("arst_next", n);
        check("arst_latency", 32'(n), 1);
        finish_xfer("arst_next", 3'b001, 3, 1'b0);

        check("sb_left", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Arbitrates the single QSPI line-transfer engine between three requesters: instruction-cache line fill (I), data-cache push/pull (D), and an auxiliary line-DMA port (X).
- Replaces the combinational ifetch-steered tag/mem mux in front of the qspi controller with a sequenced, fair, locked grant.
- Latches the winning requester's line tag, direction and memory select, and holds them until the qspi engine signals completion or a watchdog expires.

Parameters:
- PA, 24, physical address width in bits.
- LINE_LENGTH, 4, cache line length in bytes; tags are [PA-1:$clog2(LINE_LENGTH)].
- TIMEOUT, 1023, maximum BUSY cycles before abort; must be at least 1.
- TW, 10, width of the watchdog counter; must satisfy 2**TW > TIMEOUT.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low (asserted at 0).
- rom_mode  input  2  memory-map mode from the qspi register block.
- i_req  input  1  I fill request; held until i_done.
- i_tag  input  PA-log2(LL)  I line tag.
- i_done  output  1  1-cycle completion pulse to I.
- d_req  input  1  D request; held until d_done.
- d_write  input  1  D direction: 1 = push (write-back), 0 = pull.
- d_tag  input  PA-log2(LL)  D line tag.
- d_done  output  1  1-cycle completion pulse to D.
- x_req, x_write, x_tag, x_done  same meanings for the X port.
- gnt  output  3  one-hot current grant, bit order {X,D,I}.
- m_req  output  1  request to the qspi engine.
- m_i_d  output  1  1 when the granted requester is I.
- m_write  output  1  latched direction (always 0 for I).
- m_paddr  output  PA-log2(LL)  latched tag.
- m_mem  output  2  latched device select.
- m_done  input  1  qspi transfer-complete pulse.
- busy  output  1  1 whenever state is not IDLE.
- timeout  output  1  1-cycle watchdog abort pulse.

Behaviour:
- Reset values: state=IDLE, gnt=0, m_req=0, m_i_d=0, m_write=0, m_paddr=0, m_mem=0, all *_done=0, timeout=0, busy=0, rr_last=X (so I has first priority).
- The FSM is fully registered; all outputs are flops except busy, which is decoded from state.
- IDLE:
  - If any req is high, pick a winner by round-robin, starting at the requester after rr_last (order I -> D -> X -> I).
  - On the same edge: set gnt, m_req=1, and latch tag, write, i_d and mem. Clear the counter. Go to BUSY.
  - Latency: req high in cycle 0 -> m_req high in cycle 1.
  - If no req is high, stay in IDLE.
- BUSY:
  - m_req and the latched fields are held stable.
  - Request inputs are ignored; changes to tag or write are not observed.
  - If m_done is sampled high: m_req=0, raise the granted requester's done pulse for 1 cycle, rr_last=winner, gnt=0, go to RECOVER.
  - Else if counter==TIMEOUT-1: m_req=0, timeout=1 for 1 cycle, no done pulse, rr_last=winner, gnt=0, go to RECOVER.
  - Else increment the counter.
  - If m_done and the counter expiry coincide, m_done wins and no timeout is raised.
- RECOVER:
  - One mandatory idle cycle so the qspi chip-select can deassert, then go to IDLE.
  - Minimum spacing: m_done in cycle n -> done in cycle n+1 -> next m_req in cycle n+3.
- m_mem is computed at grant from the winner's tag t and direction:
  - rom_mode 00: t[PA-1] ? 2 : 0.
  - rom_mode 01: 0.
  - rom_mode 10: t[PA-1] ? 1 : 0.
  - rom_mode 11: (winner==I || !write) ? 1 : 0.
- A rom_mode change during BUSY does not affect m_mem until the next grant.
- If a requester drops req mid-transfer, the transfer still completes and the done pulse is still issued; the requester ignores it.
- m_done outside BUSY is ignored.
- Reset asserted mid-transfer returns all state to reset values immediately. The qspi engine is reset by the same signal.
- Fairness: with all three requesting continuously, grants follow I, D, X, I, ...; no requester waits more than 2 transfers.

Decomposition:
- Shared package: requester index constants (REQ_I=0, REQ_D=1, REQ_X=2), the state encoding (IDLE, BUSY, RECOVER), and the rom_mode encodings.
- One sub-module, rr_pick3: a combinational 3-way round-robin picker taking req[2:0] and last[1:0] and returning a one-hot grant. It is reusable for other shared resources.

Test Plan:
- Reset, then i_req=1 with i_tag=0x12345 and rom_mode=00 -> cycle 1: m_req=1, gnt=001, m_i_d=1, m_paddr=0x12345, m_mem=0. m_done at cycle 5 -> i_done pulse at cycle 6, busy=0 at cycle 7.
- i_req, d_req and x_req all held high with m_done 3 cycles after each m_req -> grant order I, D, X, I, D. Each done pulse is exactly 1 cycle, and there is exactly 1 RECOVER cycle between consecutive transfers.
- d_req with d_write=1 and tag MSB=0 under rom_mode=11 -> m_mem=0. Repeat with d_write=0 -> m_mem=1. Repeat with i_req under rom_mode=10 and tag MSB=1 -> m_mem=1.
- With TIMEOUT=8, x_req=1 and no m_done -> m_req falls and the timeout pulse is raised exactly 8 cycles after m_req rose; x_done never fires; the next grant goes to I if I is requesting.
- d_tag changes and d_req drops during BUSY -> m_paddr stays unchanged; d_done still pulses after m_done. A stray m_done while IDLE produces no done pulse.
- reset driven low mid-BUSY with m_req=1 -> m_req, gnt and busy are 0 asynchronously. After release, the first grant goes to I when I and D both request.
